fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, meaning first fetch address after reset.
REQ-002 SHALL have parameter IM_ADDR_WIDTH, default 10, meaning instruction-memory word-address width (1024 words).
REQ-003 SHALL have port clock  input  1  rising-edge clock, the block's only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register (load-use hazard from decode).
REQ-006 SHALL have port jumpEnabled  input  1  decode-stage taken jump/branch this cycle.
REQ-007 SHALL have port jumpTarget  input  32  redirect address, valid when jumpEnabled=1.
REQ-008 SHALL have port halt  input  1  syscall retired; stop fetching.
REQ-009 SHALL have port imAddress  output  IM_ADDR_WIDTH  word address to instruction memory, pc[IM_ADDR_WIDTH+1:2], combinational.
REQ-010 SHALL have port imData  input  32  instruction word, same-cycle combinational read.
REQ-011 SHALL have port pc  output  32  current fetch PC (registered).
REQ-012 SHALL have port ifidInstruction  output  32  IF/ID instruction, typed instruction_t, fed to decode/controller.
REQ-013 SHALL have port ifidPc  output  32  PC of ifidInstruction; decode uses it for PC+8 link and relative targets.
REQ-014 SHALL have port ifidValid  output  1  ifidInstruction is a real instruction, not a bubble.
REQ-015 SHALL have port halted  output  1  block is in HALTED state.

Function
REQ-016 SHALL implement a two-state FSM: RUN, HALTED; RUN->HALTED when halt=1; HALTED exits only on reset.
REQ-017 In RUN with halt=0, stall=0, jumpEnabled=0: SHALL set pc<=pc+4 and IF/ID<={imData, pc, valid=1} on each edge.
REQ-018 In RUN with jumpEnabled=1, stall=0: SHALL set pc<=jumpTarget and still latch the current fetch into IF/ID (branch-delay slot, no flush).
REQ-019 With stall=1 in RUN: SHALL hold pc and all IF/ID outputs unchanged; jumpEnabled SHALL be ignored (decode re-presents it next cycle).
REQ-020 Priority SHALL be reset > halt > stall > jumpEnabled > sequential.
REQ-021 On entering and while in HALTED: pc frozen, ifidInstruction=0 (NOP), ifidValid=0, ifidPc held, halted=1.
REQ-022 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-023 jumpTarget bits [1:0] SHALL be forced to 0 when loaded into pc.
REQ-024 imAddress SHALL drop pc upper bits beyond IM_ADDR_WIDTH+1 (address wraps within memory).

Reset
REQ-025 On reset=1 at an edge: pc=PC_RESET, ifidInstruction=0, ifidPc=0, ifidValid=0, halted=0, state=RUN; applies mid-stall, mid-jump and in HALTED.
REQ-026 First cycle after reset release SHALL fetch at PC_RESET; ifidValid rises one edge later.

Configuration
REQ-027 Macro FETCH_PERF_COUNTERS_EN defined: SHALL add outputs fetchCount[31:0] (increments on each valid IF/ID load) and stallCount[31:0] (increments per stall=1 cycle in RUN), both reset to 0, wrap at 2^32.
REQ-028 Macro undefined: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 instruction_t, fetch FSM state enum and the NOP constant SHALL live in the shared pipeline package used by the controller unit.
REQ-030 SHALL instantiate one sub-module, pipeline_register, parameterised by width, with enable (=!stall) and synchronous clear, holding the IF/ID bundle.

Verification
REQ-031 Reset, PC_RESET=32'h3000, imData=addr-tagged words, no stall -> pc 3000,3004,3008; ifidPc trails by one cycle; ifidValid=1 from 2nd edge.
REQ-032 jumpEnabled=1, jumpTarget=32'h3100 while pc=32'h3008 -> ifidPc=3008 (delay slot kept), next pc=3100 then 3104.
REQ-033 stall=1 for 3 cycles with jumpEnabled=1, target 32'h3200 -> pc and IF/ID unchanged for 3 cycles; stallCount+=3 when enabled.
REQ-034 halt=1 together with stall=1 and jumpEnabled=1 -> HALTED next edge, halted=1, ifidValid=0, ifidInstruction=0, pc frozen; reset then restores pc=32'h3000.
REQ-035 jumpTarget=32'hFFFF_FFFE -> pc=32'hFFFF_FFFC, next pc=0, imAddress=0x3FF then 0x000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared pipeline definitions used by the fetch stage and the controller
//   unit: the instruction word type, the NOP encoding, the fetch FSM state
//   enum, the IF/ID bundle layout and PC helper functions.
// ----------------------------------------------------------------------------
package fetch_stage_pkg;

    // Raw 32-bit instruction word as carried through the pipeline.
    typedef logic [31:0] instruction_t;

    // All-zero word decodes as a no-operation (sll $0,$0,0).
    localparam instruction_t NOP = 32'h0000_0000;

    // Byte increment between sequential fetches.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Clears the byte-offset bits so every fetch address is word aligned.
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Fetch FSM states.
    typedef enum logic [0:0] {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    // IF/ID pipeline register contents.
    typedef struct packed {
        instruction_t instr;
        logic [31:0]  pc;
        logic         valid;
    } ifid_t;

    localparam int unsigned IFID_WIDTH = $bits(ifid_t);

    // Sequential successor of a fetch address, modulo 2^32.
    function automatic logic [31:0] pc_next_seq(input logic [31:0] cur);
        return cur + PC_STEP;
    endfunction

    // Redirect target forced onto a word boundary.
    function automatic logic [31:0] pc_align(input logic [31:0] target);
        return target & PC_ALIGN_MASK;
    endfunction

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_pipeline_register.sv
// ----------------------------------------------------------------------------
// pipeline_register
//   Generic width-parameterised pipeline register with a synchronous clear
//   (dominant) and a load enable.
//
//   Ports:
//     clk_i     rising-edge clock
//     clear_i   synchronous clear, forces q_o to all zeros
//     enable_i  load d_i when high, hold otherwise
//     d_i       next contents
//     q_o       registered contents
// ----------------------------------------------------------------------------
module pipeline_register #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            data_q <= '0;
        end else if (enable_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : pipeline_register

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage: owns the PC, reads instruction memory
//   combinationally and loads the IF/ID pipeline register. Supports decode
//   stalls, delayed-branch redirects (the delay-slot instruction is kept)
//   and a terminal HALTED state left only through reset.
//
//   Parameters:
//     PC_RESET       first fetch address after reset
//     IM_ADDR_WIDTH  instruction-memory word-address width
//
//   Ports:
//     clock            rising-edge clock
//     reset            synchronous active-high reset
//     stall            hold PC and IF/ID (load-use hazard)
//     jumpEnabled      decode-stage taken jump/branch
//     jumpTarget       redirect address
//     halt             syscall retired, stop fetching
//     imAddress        instruction-memory word address (combinational)
//     imData           instruction word read at imAddress
//     pc               current fetch PC
//     ifidInstruction  IF/ID instruction (NOP while halted)
//     ifidPc           PC of ifidInstruction
//     ifidValid        IF/ID holds a real instruction
//     halted           fetch FSM is in HALTED
//
//   Build option FETCH_PERF_COUNTERS_EN adds fetchCount / stallCount outputs.
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET      = 32'h0000_3000,
    parameter int unsigned IM_ADDR_WIDTH = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     jumpEnabled,
    input  logic [31:0]              jumpTarget,
    input  logic                     halt,
    output logic [IM_ADDR_WIDTH-1:0] imAddress,
    input  logic [31:0]              imData,
    output logic [31:0]              pc,
    output instruction_t             ifidInstruction,
    output logic [31:0]              ifidPc,
    output logic                     ifidValid,
    output logic                     halted
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]              fetchCount,
    output logic [31:0]              stallCount
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         halted_q;

    ifid_t        ifid_q, ifid_d;
    logic         ifid_en;

    // Next-state decode; priority halt > stall > jump > sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        ifid_en = 1'b0;

        unique case (state_q)
            FETCH_RUN: begin
                if (halt) begin
                    // Bubble into decode but keep the last PC for debug.
                    state_d      = FETCH_HALTED;
                    ifid_d.instr = NOP;
                    ifid_d.pc    = ifid_q.pc;
                    ifid_d.valid = 1'b0;
                    ifid_en      = 1'b1;
                end else if (!stall) begin
                    // Current fetch is latched even on a redirect: it is
                    // the branch-delay slot.
                    ifid_d.instr = imData;
                    ifid_d.pc    = pc_q;
                    ifid_d.valid = 1'b1;
                    ifid_en      = 1'b1;
                    pc_d = jumpEnabled ? pc_align(jumpTarget) : pc_next_seq(pc_q);
                end
            end
            FETCH_HALTED: begin
                state_d = FETCH_HALTED;
            end
            default: begin
                state_d = FETCH_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FETCH_RUN;
            pc_q     <= PC_RESET;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= (state_d == FETCH_HALTED);
        end
    end

    logic [IFID_WIDTH-1:0] ifid_q_raw;

    pipeline_register #(
        .WIDTH (IFID_WIDTH)
    ) u_ifid_reg (
        .clk_i    (clock),
        .clear_i  (reset),
        .enable_i (ifid_en),
        .d_i      (ifid_d),
        .q_o      (ifid_q_raw)
    );

    assign ifid_q = ifid_t'(ifid_q_raw);

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Halt outranks stall, so a halting cycle is not counted as a stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (state_q == FETCH_RUN && !halt) begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    assign fetchCount = fetch_cnt_q;
    assign stallCount = stall_cnt_q;
`endif

    assign imAddress       = pc_q[IM_ADDR_WIDTH+1:2];
    assign pc              = pc_q;
    assign ifidInstruction = ifid_q.instr;
    assign ifidPc          = ifid_q.pc;
    assign ifidValid       = ifid_q.valid;
    assign halted          = halted_q;

endmodule : fetch_stage
